// File: rtl/div_unit.sv
// Iterative 64/32-bit integer divider for the RV64M divide/remainder ops.
// Radix-2 restoring algorithm, one quotient bit per clock. Divide-by-zero and
// signed overflow bypass the iteration and complete at the accept edge.
module div_unit (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [2:0]  op,
  input  logic [63:0] a,
  input  logic [63:0] b,
  input  logic        flush,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [63:0] result
);

  typedef enum logic [1:0] {StIdle, StCalc, StDone} state_e;

  state_e      state_q, state_d;
  logic [5:0]  cnt_q, cnt_d;
  logic [63:0] rem_q, rem_d;        // partial remainder
  logic [63:0] quo_q, quo_d;        // dividend shifted out / quotient shifted in
  logic [63:0] div_q, div_d;        // divisor magnitude
  logic        w_q, w_d;
  logic        rem_sel_q, rem_sel_d;
  logic        neg_quo_q, neg_quo_d;
  logic        neg_rem_q, neg_rem_d;
  logic        out_valid_q, out_valid_d;
  logic [63:0] result_q, result_d;

  // Request decode: operand signs, magnitudes and the two bypass cases
  logic        is_w, is_sgn, is_rem;
  logic        a_neg, b_neg, b_zero, ovf;
  logic [63:0] a_mag, b_mag, a_sext, fast_res;
  logic [31:0] a_lo_neg, b_lo_neg;
  logic [63:0] a_neg_full, b_neg_full;

  always_comb begin
    is_w       = op[2];
    is_sgn     = ~op[0];
    is_rem     = op[1];
    a_neg      = is_sgn & (is_w ? a[31] : a[63]);
    b_neg      = is_sgn & (is_w ? b[31] : b[63]);
    a_lo_neg   = ~a[31:0] + 32'd1;
    b_lo_neg   = ~b[31:0] + 32'd1;
    a_neg_full = ~a + 64'd1;
    b_neg_full = ~b + 64'd1;
    if (is_w) begin
      a_mag = {32'd0, a_neg ? a_lo_neg : a[31:0]};
      b_mag = {32'd0, b_neg ? b_lo_neg : b[31:0]};
    end else begin
      a_mag = a_neg ? a_neg_full : a;
      b_mag = b_neg ? b_neg_full : b;
    end
    a_sext = is_w ? {{32{a[31]}}, a[31:0]} : a;
    b_zero = is_w ? (b[31:0] == 32'd0) : (b == 64'd0);
    ovf    = is_sgn & (is_w ? (a[31:0] == 32'h8000_0000 && b[31:0] == 32'hFFFF_FFFF)
                            : (a == 64'h8000_0000_0000_0000 && b == 64'hFFFF_FFFF_FFFF_FFFF));
    if (b_zero) begin
      fast_res = is_rem ? a_sext : 64'hFFFF_FFFF_FFFF_FFFF;
    end else begin
      fast_res = is_rem ? 64'd0 : a_sext;
    end
  end

  // One restoring step plus the sign fix-up applied on the final step
  logic [64:0] shifted;
  logic        ge;
  logic [63:0] rem_nx, quo_nx;
  logic [31:0] q32, r32, sel32;
  logic [63:0] q64, r64, final_res;
  logic        last;

  always_comb begin
    shifted   = {rem_q, quo_q[63]};
    ge        = shifted >= {1'b0, div_q};
    // When ge holds the true difference is below div_q, so 64-bit wrap is exact
    rem_nx    = ge ? (shifted[63:0] - div_q) : shifted[63:0];
    quo_nx    = {quo_q[62:0], ge};
    q32       = neg_quo_q ? (~quo_nx[31:0] + 32'd1) : quo_nx[31:0];
    r32       = neg_rem_q ? (~rem_nx[31:0] + 32'd1) : rem_nx[31:0];
    sel32     = rem_sel_q ? r32 : q32;
    q64       = neg_quo_q ? (~quo_nx + 64'd1) : quo_nx;
    r64       = neg_rem_q ? (~rem_nx + 64'd1) : rem_nx;
    final_res = w_q ? {{32{sel32[31]}}, sel32} : (rem_sel_q ? r64 : q64);
    last      = (cnt_q == (w_q ? 6'd31 : 6'd63));
  end

  // Next-state logic; flush overrides everything and blocks a same-edge accept
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    rem_d       = rem_q;
    quo_d       = quo_q;
    div_d       = div_q;
    w_d         = w_q;
    rem_sel_d   = rem_sel_q;
    neg_quo_d   = neg_quo_q;
    neg_rem_d   = neg_rem_q;
    out_valid_d = out_valid_q;
    result_d    = result_q;
    unique case (state_q)
      StIdle: begin
        if (in_valid && !flush) begin
          w_d       = is_w;
          rem_sel_d = is_rem;
          neg_quo_d = a_neg ^ b_neg;
          neg_rem_d = a_neg;
          if (b_zero || ovf) begin
            state_d     = StDone;
            out_valid_d = 1'b1;
            result_d    = fast_res;
          end else begin
            state_d = StCalc;
            cnt_d   = 6'd0;
            rem_d   = 64'd0;
            // W dividends sit in the top half so 32 shifts consume them fully
            quo_d   = is_w ? {a_mag[31:0], 32'd0} : a_mag;
            div_d   = b_mag;
          end
        end
      end
      StCalc: begin
        rem_d = rem_nx;
        quo_d = quo_nx;
        cnt_d = cnt_q + 6'd1;
        if (last) begin
          state_d     = StDone;
          cnt_d       = 6'd0;
          out_valid_d = 1'b1;
          result_d    = final_res;
        end
      end
      StDone: begin
        if (out_ready) begin
          state_d     = StIdle;
          out_valid_d = 1'b0;
        end
      end
      default: state_d = StIdle;
    endcase
    if (flush) begin
      state_d     = StIdle;
      cnt_d       = 6'd0;
      out_valid_d = 1'b0;
    end
  end

  // State and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      cnt_q       <= 6'd0;
      rem_q       <= 64'd0;
      quo_q       <= 64'd0;
      div_q       <= 64'd0;
      w_q         <= 1'b0;
      rem_sel_q   <= 1'b0;
      neg_quo_q   <= 1'b0;
      neg_rem_q   <= 1'b0;
      out_valid_q <= 1'b0;
      result_q    <= 64'd0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      rem_q       <= rem_d;
      quo_q       <= quo_d;
      div_q       <= div_d;
      w_q         <= w_d;
      rem_sel_q   <= rem_sel_d;
      neg_quo_q   <= neg_quo_d;
      neg_rem_q   <= neg_rem_d;
      out_valid_q <= out_valid_d;
      result_q    <= result_d;
    end
  end

  assign in_ready  = (state_q == StIdle);
  assign out_valid = out_valid_q;
  assign result    = result_q;

endmodule

// File: tb/tb_div_unit.sv
// Directed-vector bench for div_unit: a table of ops with hand-computed
// results and completion edge counts, plus sequences for back-pressure,
// flush and asynchronous reset.
module tb_div_unit;

  localparam logic [2:0] OpDiv   = 3'b000;
  localparam logic [2:0] OpDivu  = 3'b001;
  localparam logic [2:0] OpRem   = 3'b010;
  localparam logic [2:0] OpRemu  = 3'b011;
  localparam logic [2:0] OpDivw  = 3'b100;
  localparam logic [2:0] OpDivuw = 3'b101;
  localparam logic [2:0] OpRemw  = 3'b110;
  localparam logic [2:0] OpRemuw = 3'b111;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  op;
  logic [63:0] a;
  logic [63:0] b;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] result;

  div_unit dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .op       (op),
    .a        (a),
    .b        (b),
    .flush    (flush),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .result   (result)
  );

  always #5 clk = ~clk;

  // edges: posedges after the accept edge until out_valid (0 = DONE at accept)
  typedef struct {
    logic [2:0]  op;
    logic [63:0] a;
    logic [63:0] b;
    logic [63:0] exp;
    int          edges;
  } vec_t;

  vec_t vecs[$];
  int   n_vec = 0;
  int   n_cmp = 0;
  int   n_err = 0;

  task automatic add(input logic [2:0] o, input logic [63:0] va, input logic [63:0] vb,
                     input logic [63:0] e, input int ed);
    vec_t v;
    v.op = o; v.a = va; v.b = vb; v.exp = e; v.edges = ed;
    vecs.push_back(v);
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, required %h", name, act, exp);
    end
  endtask

  // Drive a request on the next negedge, return #1 after its accept edge with
  // the operand inputs scrambled so late changes would corrupt the result.
  task automatic accept(input logic [2:0] o, input logic [63:0] va, input logic [63:0] vb);
    @(negedge clk);
    check("in_ready_before_accept", {63'd0, in_ready}, 64'd1);
    op = o; a = va; b = vb; in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    op = ~o; a = ~va; b = ~vb;
  endtask

  task automatic wait_out(output int cyc);
    cyc = 0;
    while (!out_valid && cyc < 200) begin
      @(posedge clk);
      #1;
      cyc++;
    end
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    int cyc;
    out_ready = 1'b1;
    accept(v.op, v.a, v.b);
    wait_out(cyc);
    check($sformatf("v%0d_latency", idx), 64'(cyc), 64'(v.edges));
    check($sformatf("v%0d_result", idx), result, v.exp);
    @(posedge clk);
    #1;
    check($sformatf("v%0d_valid_single", idx), {63'd0, out_valid}, 64'd0);
    check($sformatf("v%0d_back_idle", idx), {63'd0, in_ready}, 64'd1);
    n_vec++;
  endtask

  // Counts out_valid highs over a window of edges
  task automatic quiet_window(input string name, input int n);
    int highs = 0;
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      if (out_valid) highs++;
    end
    check(name, 64'(highs), 64'd0);
  endtask

  initial begin
    int cyc;
    logic [63:0] held;

    add(OpDivu,  64'd100, 64'd7, 64'd14, 64);
    add(OpRemu,  64'd100, 64'd7, 64'd2, 64);
    add(OpDiv,   64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFD, 64);
    add(OpRem,   64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF, 64);
    add(OpDiv,   64'd5, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 0);
    add(OpRemu,  64'd5, 64'd0, 64'd5, 0);
    add(OpRemw,  64'h0000_0000_8000_0001, 64'd0, 64'hFFFF_FFFF_8000_0001, 0);
    add(OpDiv,   64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF,
                 64'h8000_0000_0000_0000, 0);
    add(OpRem,   64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 0);
    add(OpDivw,  64'h0000_0000_8000_0000, 64'h0000_0000_FFFF_FFFF,
                 64'hFFFF_FFFF_8000_0000, 0);
    add(OpDivw,  64'd5, 64'h0000_0001_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 0);
    add(OpDivuw, 64'h0000_0000_FFFF_FFFF, 64'd1, 64'hFFFF_FFFF_FFFF_FFFF, 32);
    add(OpDivuw, 64'h0000_0000_8000_0000, 64'd1, 64'hFFFF_FFFF_8000_0000, 32);
    add(OpDivw,  64'h1234_5678_FFFF_FF9C, 64'hABCD_0000_0000_0007,
                 64'hFFFF_FFFF_FFFF_FFF2, 32);
    add(OpRemw,  64'h1234_5678_FFFF_FF9C, 64'hABCD_0000_0000_0007,
                 64'hFFFF_FFFF_FFFF_FFFE, 32);
    add(OpRemuw, 64'h1234_5678_8000_0005, 64'h0000_0000_7FFF_FFFF, 64'd6, 32);
    add(OpDivu,  64'hFFFF_FFFF_FFFF_FFFF, 64'd3, 64'h5555_5555_5555_5555, 64);
    add(OpDiv,   64'd7, 64'hFFFF_FFFF_FFFF_FFFE, 64'hFFFF_FFFF_FFFF_FFFD, 64);
    add(OpRem,   64'd7, 64'hFFFF_FFFF_FFFF_FFFE, 64'd1, 64);
    add(OpDiv,   64'h7FFF_FFFF_FFFF_FFFF, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 64);
    add(OpDivu,  64'h0123_4567_89AB_CDEF, 64'h100, 64'h0001_2345_6789_ABCD, 64);
    add(OpRemu,  64'h0123_4567_89AB_CDEF, 64'h100, 64'hEF, 64);

    rst_n = 1'b0; in_valid = 1'b0; op = 3'd0; a = 64'd0; b = 64'd0;
    flush = 1'b0; out_ready = 1'b1;
    #12;
    check("reset_out_valid", {63'd0, out_valid}, 64'd0);
    check("reset_result", result, 64'd0);
    check("reset_in_ready", {63'd0, in_ready}, 64'd1);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("post_reset_in_ready", {63'd0, in_ready}, 64'd1);

    for (int i = 0; i < vecs.size(); i++) run_vec(vecs[i], i);

    // Back-pressure: result held while out_ready is low; no accept meanwhile
    out_ready = 1'b0;
    accept(OpDivuw, 64'h0000_0000_FFFF_FFFF, 64'd1);
    wait_out(cyc);
    check("hold_latency", 64'(cyc), 64'd32);
    check("hold_result", result, 64'hFFFF_FFFF_FFFF_FFFF);
    held = 64'hFFFF_FFFF_FFFF_FFFF;
    in_valid = 1'b1; op = OpDivu; a = 64'd9; b = 64'd0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1;
      check($sformatf("hold_valid_%0d", i), {63'd0, out_valid}, 64'd1);
      check($sformatf("hold_result_%0d", i), result, held);
      check($sformatf("hold_in_ready_%0d", i), {63'd0, in_ready}, 64'd0);
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    check("release_valid", {63'd0, out_valid}, 64'd0);
    check("release_no_accept", {63'd0, in_ready}, 64'd1);
    quiet_window("release_quiet", 3);
    n_vec++;

    // Flush after 20 iterations
    accept(OpDivu, 64'd100, 64'd7);
    repeat (19) @(posedge clk);
    #1;
    flush = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0;
    check("flush_idle", {63'd0, in_ready}, 64'd1);
    check("flush_valid", {63'd0, out_valid}, 64'd0);
    quiet_window("flush_quiet", 70);
    n_vec++;

    // Flush in IDLE masks a simultaneous request (a div-by-zero would finish at once)
    @(negedge clk);
    flush = 1'b1; in_valid = 1'b1; op = OpDiv; a = 64'd5; b = 64'd0;
    @(posedge clk);
    #1;
    flush = 1'b0; in_valid = 1'b0;
    check("flush_blocks_accept", {63'd0, out_valid}, 64'd0);
    check("flush_stays_idle", {63'd0, in_ready}, 64'd1);
    n_vec++;

    // Asynchronous reset between edges mid-CALC
    accept(OpDivu, 64'd100, 64'd7);
    repeat (10) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check("areset_valid", {63'd0, out_valid}, 64'd0);
    check("areset_result", result, 64'd0);
    check("areset_in_ready", {63'd0, in_ready}, 64'd1);
    rst_n = 1'b1;
    quiet_window("areset_quiet", 70);
    n_vec++;
    run_vec(vecs[0], 100);

    // Asynchronous reset while holding a result in DONE
    out_ready = 1'b0;
    accept(OpDiv, 64'd5, 64'd0);
    check("done_before_reset", {63'd0, out_valid}, 64'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("done_reset_valid", {63'd0, out_valid}, 64'd0);
    check("done_reset_result", result, 64'd0);
    rst_n = 1'b1;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    check("done_reset_idle", {63'd0, in_ready}, 64'd1);
    n_vec++;
    run_vec(vecs[3], 101);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/div_unit.md
DIV_UNIT -- requirements
Module: div_unit

Interface
REQ-001 SHALL have no parameters; data width is `ARCH_WIDTH (64) from include/riscv64/common.vh.
REQ-002 SHALL have port clk  in  1  sole clock, all state on rising edge.
REQ-003 SHALL have port rst_n  in  1  reset, asynchronous, active-low.
REQ-004 SHALL have port in_valid  in  1  request valid.
REQ-005 SHALL have port in_ready  out  1  unit can accept a request.
REQ-006 SHALL have port op  in  3  operation: 000 DIV, 001 DIVU, 010 REM, 011 REMU, 100 DIVW, 101 DIVUW, 110 REMW, 111 REMUW.
REQ-007 SHALL have port a  in  64  dividend (rs1).
REQ-008 SHALL have port b  in  64  divisor (rs2).
REQ-009 SHALL have port flush  in  1  pipeline kill, synchronous.
REQ-010 SHALL have port out_valid  out  1  result valid.
REQ-011 SHALL have port out_ready  in  1  result consumer (writeback result select) ready.
REQ-012 SHALL have port result  out  64  quotient or remainder per op.

Function
REQ-013 SHALL implement FSM states IDLE, CALC, DONE; in_ready = 1 only in IDLE; out_valid = 1 only in DONE.
REQ-014 SHALL accept a request on a rising edge with in_valid && in_ready && !flush, latching op, a, b.
REQ-015 SHALL, for W ops (op[2]=1), use only a[31:0], b[31:0] as 32-bit operands and sign-extend result bit 31 to 64 bits, including DIVUW/REMUW.
REQ-016 SHALL, for signed ops, divide magnitudes and negate the quotient when operand signs differ and negate the remainder when the dividend is negative (truncating division).
REQ-017 SHALL compute by radix-2 restoring iteration, one quotient bit per cycle, N = 64 (non-W) or 32 (W) iterations.
REQ-018 SHALL, on a normal accept, enter CALC and enter DONE on the N-th edge after the accept edge (out_valid first high N cycles after accept).
REQ-019 SHALL, when divisor is zero, go directly from IDLE to DONE at the accept edge with quotient = all ones and remainder = dividend (W: sign-extended a[31:0]).
REQ-020 SHALL, on signed overflow (dividend most-negative for its width, divisor = -1), go directly to DONE with quotient = dividend (W: sign-extended) and remainder = 0.
REQ-021 SHALL hold result and out_valid stable in DONE until out_valid && out_ready, then return to IDLE on that edge; no accept occurs in the same edge.
REQ-022 SHALL, when flush = 1 at an edge, go to IDLE from any state, drop out_valid next cycle, and ignore in_valid that cycle.
REQ-023 SHALL ignore a, b, op changes after the accept edge.

Reset
REQ-024 SHALL, while rst_n = 0, force state IDLE, out_valid = 0, result = 0, iteration counter = 0, independent of clk.
REQ-025 SHALL present in_ready = 1 in the first cycle after rst_n deasserts; a reset mid-CALC or in DONE discards the operation with no out_valid.

Verification
REQ-026 DIVU a=100, b=7, out_ready=1 -> result 14, out_valid high exactly 64 cycles after accept, single cycle; REMU -> 2.
REQ-027 DIV a=0xFFFF_FFFF_FFFF_FFF9 (-7), b=2 -> 0xFFFF_FFFF_FFFF_FFFD (-3); REM same operands -> 0xFFFF_FFFF_FFFF_FFFF (-1).
REQ-028 DIV a=5, b=0 -> 0xFFFF_FFFF_FFFF_FFFF after 1 cycle; REMU a=5, b=0 -> 5; REMW a=0x0000_0000_8000_0001, b=0 -> 0xFFFF_FFFF_8000_0001.
REQ-029 DIV a=0x8000_0000_0000_0000, b=all ones -> 0x8000_0000_0000_0000, 1-cycle latency; REM -> 0; DIVW a=0x8000_0000, b=0xFFFF_FFFF -> 0xFFFF_FFFF_8000_0000.
REQ-030 DIVUW a=0xFFFF_FFFF, b=1 -> 0xFFFF_FFFF_FFFF_FFFF at 32 cycles; hold out_ready=0 for 10 cycles -> result/out_valid unchanged, in_ready=0 throughout.
REQ-031 Flush at CALC iteration 20 -> IDLE next cycle, no out_valid; rst_n pulsed low mid-CALC between clock edges -> out_valid=0, result=0 immediately; next request completes correctly.
